// File: rtl/shift_result_stage.sv
// Writeback buffer between the shifter and the register file. Results drain in order,
// and the architectural Z/C flags commit only when a flag-enabled entry retires.
module shift_result_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      shift_out,
  input  logic                   Z,
  input  logic                   C,
  input  logic [ADDR_W-1:0]      dest_addr,
  input  logic                   flag_en,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [DATA_W-1:0]      wb_data,
  output logic [ADDR_W-1:0]      wb_addr,
  output logic                   z_flag,
  output logic                   c_flag,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic              z_mem    [DEPTH];
  logic              c_mem    [DEPTH];
  logic              fe_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  // Handshake terms depend only on registered occupancy, so wb_ready never reaches in_ready.
  assign in_ready = (count < FULL);
  assign wb_valid = (count != '0);
  assign push     = in_valid && in_ready;
  assign pop      = wb_valid && wb_ready;

  assign wb_data  = data_mem[rd_ptr];
  assign wb_addr  = addr_mem[rd_ptr];

  // Entry storage carries no reset; contents are meaningless until counted valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      data_mem[wr_ptr] <= shift_out;
      addr_mem[wr_ptr] <= dest_addr;
      z_mem[wr_ptr]    <= Z;
      c_mem[wr_ptr]    <= C;
      fe_mem[wr_ptr]   <= flag_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      z_flag <= 1'b0;
      c_flag <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (fe_mem[rd_ptr]) begin
          z_flag <= z_mem[rd_ptr];
          c_flag <= c_mem[rd_ptr];
        end
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_result_stage.sv
// Scoreboard bench for shift_result_stage: a reference queue of accepted entries plus a
// flag model predicts occupancy, head contents and committed flags every cycle.
module tb_shift_result_stage;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 2;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] shift_out;
  logic              Z;
  logic              C;
  logic [ADDR_W-1:0] dest_addr;
  logic              flag_en;
  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] wb_addr;
  logic              z_flag;
  logic              c_flag;
  logic [$clog2(DEPTH):0] count;

  shift_result_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .shift_out(shift_out), .Z(Z), .C(C), .dest_addr(dest_addr), .flag_en(flag_en),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_addr(wb_addr),
    .z_flag(z_flag), .c_flag(c_flag), .count(count)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              z;
    logic              c;
    logic              fe;
  } entry_t;

  entry_t q[$];
  logic   exp_z;
  logic   exp_c;
  int     n_vec;
  int     n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT state against the reference, then retires what the edge will retire.
  always @(negedge clk) begin : monitor
    entry_t e;
    if (!rst_n) begin
      q.delete();
      exp_z = 1'b0;
      exp_c = 1'b0;
    end else begin
      chk("count", 32'(count), q.size());
      chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      chk("wb_valid", 32'(wb_valid), 32'(q.size() != 0));
      chk("z_flag", 32'(z_flag), 32'(exp_z));
      chk("c_flag", 32'(c_flag), 32'(exp_c));
      if (q.size() != 0) begin
        chk("wb_data", 32'(wb_data), 32'(q[0].data));
        chk("wb_addr", 32'(wb_addr), 32'(q[0].addr));
      end
      if (flush) begin
        q.delete();
      end else if (wb_ready && q.size() != 0) begin
        e = q.pop_front();
        if (e.fe) begin
          exp_z = e.z;
          exp_c = e.c;
        end
      end
    end
  end

  // Driver: presents one cycle of stimulus from posedge+1; an accepted push enters the scoreboard.
  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a,
                       input logic z, input logic c, input logic fe, input logic rdy,
                       input logic fl);
    entry_t e;
    logic   acc;
    in_valid  = v;
    shift_out = d;
    dest_addr = a;
    Z         = z;
    C         = c;
    flag_en   = fe;
    wb_ready  = rdy;
    flush     = fl;
    @(negedge clk);
    acc = rst_n && v && in_ready && !fl;
    #1;
    if (acc) begin
      e.data = d; e.addr = a; e.z = z; e.c = c; e.fe = fe;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_z = 1'b0;
    exp_c = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b0; shift_out = '0; dest_addr = '0; Z = 1'b0; C = 1'b0;
    flag_en = 1'b0; wb_ready = 1'b0; flush = 1'b0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_flags", {30'd0, z_flag, c_flag}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Single push with immediate drain; push lands on the first edge after reset release.
    drive(1'b1, 8'h5A, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("lat_wb_valid", 32'(wb_valid), 1);
    chk("lat_wb_data", 32'(wb_data), 32'h5A);
    chk("lat_wb_addr", 32'(wb_addr), 3);
    idle(1'b1, 1);
    chk("pop_flags", {30'd0, z_flag, c_flag}, 32'b01);
    chk("pop_count", 32'(count), 0);

    // Fill to full under back-pressure, attempt a third push, then drain in order.
    drive(1'b1, 8'h11, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_count", 32'(count), 2);
    chk("full_in_ready", 32'(in_ready), 0);
    drive(1'b1, 8'h33, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_hold_count", 32'(count), 2);
    chk("full_head", 32'(wb_data), 32'h11);
    idle(1'b1, 3);

    // Steady push+pop at occupancy one wraps both pointers several times.
    drive(1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 8'(i), 3'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("stream_count", 32'(count), 1);
      chk("stream_head", 32'(wb_data), 32'(i));
    end
    idle(1'b1, 2);

    // Flag commit only for flag-enabled entries.
    drive(1'b1, 8'hA0, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 1);
    drive(1'b1, 8'hA1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 1);
    chk("fe0_flags", {30'd0, z_flag, c_flag}, 32'b00);
    drive(1'b1, 8'hA2, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 1);
    chk("fe1_flags", {30'd0, z_flag, c_flag}, 32'b10);

    // Flush beats a same-cycle push and pop.
    drive(1'b1, 8'hB1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'hB2, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'hB3, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("flush_count", 32'(count), 0);
    chk("flush_wb_valid", 32'(wb_valid), 0);
    chk("flush_flags", {30'd0, z_flag, c_flag}, 32'b10);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom_range(0, 15) == 0));
    end
    idle(1'b1, 3);

    // Asynchronous reset between edges with two entries held and flags set.
    drive(1'b1, 8'hC0, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 1);
    drive(1'b1, 8'hC1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'hC2, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count), 2);
    chk("pre_rst_flags", {30'd0, z_flag, c_flag}, 32'b11);
    in_valid = 1'b0; wb_ready = 1'b1; flush = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_wb_valid", 32'(wb_valid), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_flags", {30'd0, z_flag, c_flag}, 32'b00);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 8'hD4, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_push", 32'(count), 1);
    idle(1'b1, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_result_stage.md
SHIFT_RESULT_STAGE -- requirements
Module: shift_result_stage

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of the shift result carried per entry.
REQ-002 Parameter ADDR_W, default 3, SHALL set the width of the destination register address.
REQ-003 Parameter DEPTH, default 2, SHALL set the number of buffer entries; legal values are powers of two, 2 or greater.
REQ-004 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 flush  input  1  SHALL be a synchronous discard of all buffered entries.
REQ-007 in_valid  input  1  SHALL indicate the shifter result is presented this cycle.
REQ-008 in_ready  output  1  SHALL indicate the stage accepts an entry this cycle.
REQ-009 shift_out  input  DATA_W  SHALL carry the shifter result.
REQ-010 Z  input  1  SHALL carry the shifter zero flag.
REQ-011 C  input  1  SHALL carry the shifter carry-out flag.
REQ-012 dest_addr  input  ADDR_W  SHALL carry the destination register index.
REQ-013 flag_en  input  1  SHALL mark whether this result updates the status flags.
REQ-014 wb_valid  output  1  SHALL indicate a writeback is presented.
REQ-015 wb_ready  input  1  SHALL indicate the register file consumes the writeback.
REQ-016 wb_data  output  DATA_W  SHALL carry the head entry's result.
REQ-017 wb_addr  output  ADDR_W  SHALL carry the head entry's destination.
REQ-018 z_flag  output  1  SHALL carry the committed architectural zero flag.
REQ-019 c_flag  output  1  SHALL carry the committed architectural carry flag.
REQ-020 count  output  $clog2(DEPTH)+1  SHALL carry the current occupancy.

Function
REQ-021 Each entry SHALL hold {shift_out, dest_addr, Z, C, flag_en}, captured at the push edge.
REQ-022 A push SHALL occur when in_valid=1 and in_ready=1; a pop SHALL occur when wb_valid=1 and wb_ready=1.
REQ-023 in_ready SHALL equal (count < DEPTH), derived from registered state only, with no combinational path from wb_ready.
REQ-024 wb_valid SHALL equal (count != 0); wb_data and wb_addr SHALL come from the head entry.
REQ-025 Latency SHALL be one cycle: an entry pushed at edge N appears on wb_* in the cycle after edge N when the buffer was empty.
REQ-026 While wb_valid=1 and wb_ready=0, wb_data and wb_addr SHALL remain stable.
REQ-027 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-028 When full, in_ready=0, so no push SHALL occur; a pop in the same cycle makes in_ready=1 only in the following cycle.
REQ-029 A pop of an empty buffer SHALL be impossible because wb_valid=0; wb_ready is ignored when empty.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH, and count SHALL never exceed DEPTH or go below 0.
REQ-031 On a pop of an entry with flag_en=1, z_flag and c_flag SHALL load that entry's Z and C at the same edge.
REQ-032 On a pop of an entry with flag_en=0, z_flag and c_flag SHALL hold their values.
REQ-033 Flags SHALL update only on pop, never on push.
REQ-034 When flush=1, at the next edge count and both pointers SHALL clear to 0, and z_flag and c_flag SHALL hold.
REQ-035 flush SHALL take priority over a same-cycle push or pop; neither the push nor the pop takes effect, and no flag update occurs.

Reset
REQ-036 While rst_n=0, the stage SHALL immediately force count=0, both pointers to 0, wb_valid=0, in_ready=1 (derived), z_flag=0, c_flag=0.
REQ-037 Entry storage SHALL need no reset, and wb_data and wb_addr SHALL be don't-care while wb_valid=0.
REQ-038 Reset asserted mid-operation SHALL discard all entries, and no pop or flag update SHALL occur on that edge.
REQ-039 After rst_n deasserts, the first push SHALL be accepted on the first rising edge.

Verification
REQ-040 Push {0x5A, addr 3, Z=0, C=1, flag_en=1} with wb_ready=1 -> next cycle wb_valid=1, wb_data=0x5A, wb_addr=3; after the pop, z_flag=0, c_flag=1, count=0.
REQ-041 With wb_ready=0, push 0x11 then 0x22 -> count=2, in_ready=0, and a third in_valid is not accepted; with wb_ready=1, pops return 0x11 then 0x22.
REQ-042 With count=1, hold in_valid=1 and wb_ready=1 for 6 cycles with data 0x01..0x06 -> count stays 1, outputs are in order, and pointers wrap.
REQ-043 Pop {Z=1, C=1, flag_en=0} when z_flag=0, c_flag=0 -> flags remain 0,0; pop a flag_en=1 entry {Z=1, C=0} -> flags become 1,0.
REQ-044 With count=2, assert flush together with in_valid and wb_ready -> next cycle count=0, wb_valid=0, flags unchanged.
REQ-045 With count=2 and flags 1,1, pull rst_n low between edges -> wb_valid=0, count=0, z_flag=0, c_flag=0 asynchronously, before the next edge.
